// File: rtl/rs_issue_scheduler_pkg.sv
// Shared sizing constants and slicing helpers for the issue scheduler
// and the issue queue that owns operands and payload.
package rs_issue_scheduler_pkg;

  localparam int RS_SIZE  = 64;
  localparam int IDX_W    = 6;
  localparam int FU_ARRAY = 3;
  localparam int FU_SIZE  = 2;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [FU_SIZE-1:0] fu_t;

  typedef logic [RS_SIZE*FU_SIZE-1:0] entry_fu_vec_t;
  typedef logic [FU_ARRAY*IDX_W-1:0]  grant_idx_vec_t;

  function automatic fu_t entry_fu(
    input entry_fu_vec_t v,
    input int            i
  );
    return v[i*FU_SIZE +: FU_SIZE];
  endfunction

  function automatic idx_t grant_idx(
    input grant_idx_vec_t v,
    input int             f
  );
    return v[f*IDX_W +: IDX_W];
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_rr_picker.sv
// Rotating-priority picker: first set request at or above start,
// wrapping from N-1 back to 0.
module rr_picker #(
  parameter int N = 64,
  parameter int W = 6
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  localparam int PW = W + 1;

  logic [PW-1:0] pos;

  // Scan from the far end so the nearest hit is assigned last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, start} + PW'(k);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (req[pos[W-1:0]]) begin
        found = 1'b1;
        idx   = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Slot allocator and per-FU rotating-priority issue arbiter
// for the unified issue queue.
module rs_issue_scheduler #(
  parameter int RS_SIZE  = rs_issue_scheduler_pkg::RS_SIZE,
  parameter int IDX_W    = rs_issue_scheduler_pkg::IDX_W,
  parameter int FU_ARRAY = rs_issue_scheduler_pkg::FU_ARRAY,
  parameter int FU_SIZE  = rs_issue_scheduler_pkg::FU_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_in,
  input  logic                      dispatch_valid_in,
  output logic                      dispatch_ready_out,
  output logic [IDX_W-1:0]          alloc_idx_out,
  output logic [FU_SIZE-1:0]        alloc_fu_out,
  input  logic [RS_SIZE-1:0]        ready_vec_in,
  input  logic [RS_SIZE*FU_SIZE-1:0] entry_fu_in,
  input  logic [FU_ARRAY-1:0]       fu_ready_in,
  output logic [FU_ARRAY-1:0]       grant_valid_out,
  output logic [FU_ARRAY*IDX_W-1:0] grant_idx_out,
  output logic [IDX_W:0]            occupancy_out,
  output logic                      full_out,
  output logic                      empty_out
);

  import rs_issue_scheduler_pkg::*;

  localparam int OW = IDX_W + 1;

  logic [RS_SIZE-1:0]                valid;
  logic [FU_ARRAY-1:0][IDX_W-1:0]    rr_ptr;
  logic [FU_SIZE-1:0]                fu_rr;
  logic [OW-1:0]                     occ;
  logic [FU_ARRAY-1:0]               grant_q;
  logic [FU_ARRAY-1:0][IDX_W-1:0]    grant_idx_q;

  logic [FU_ARRAY-1:0][RS_SIZE-1:0]  cand;
  logic [FU_ARRAY-1:0]               pick_found;
  logic [FU_ARRAY-1:0][IDX_W-1:0]    pick_idx;
  logic [FU_ARRAY-1:0][IDX_W-1:0]    ptr_next;

  logic [IDX_W-1:0]   free_idx;
  logic               full;
  logic               accept;
  logic [RS_SIZE-1:0] set_mask;
  logic [RS_SIZE-1:0] clr_mask;
  logic [OW-1:0]      n_grant;
  logic [OW-1:0]      occ_next;
  logic [FU_SIZE-1:0] fu_rr_next;

  always_comb begin
    cand = '0;
    for (int f = 0; f < FU_ARRAY; f++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        cand[f][i] = valid[i] & ready_vec_in[i] & fu_ready_in[f]
                   & (entry_fu(entry_fu_in, i) == FU_SIZE'(f));
      end
    end
  end

  for (genvar g = 0; g < FU_ARRAY; g++) begin : g_pick
    rr_picker #(
      .N (RS_SIZE),
      .W (IDX_W)
    ) u_pick (
      .req   (cand[g]),
      .start (rr_ptr[g]),
      .found (pick_found[g]),
      .idx   (pick_idx[g])
    );
  end

  // Lowest free slot; falls back to 0 when the queue is full.
  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  assign full   = (occ == OW'(RS_SIZE));
  assign accept = dispatch_valid_in & ~full & ~flush_in;

  always_comb begin
    set_mask = '0;
    if (accept) set_mask[free_idx] = 1'b1;
  end

  always_comb begin
    clr_mask = '0;
    n_grant  = '0;
    ptr_next = rr_ptr;
    for (int f = 0; f < FU_ARRAY; f++) begin
      if (pick_found[f]) begin
        clr_mask[pick_idx[f]] = 1'b1;
        n_grant     = n_grant + OW'(1);
        ptr_next[f] = (pick_idx[f] == IDX_W'(RS_SIZE - 1))
                    ? '0 : pick_idx[f] + IDX_W'(1);
      end
    end
  end

  assign occ_next = occ + OW'(accept) - n_grant;

  assign fu_rr_next = (fu_rr == FU_SIZE'(FU_ARRAY - 1))
                    ? '0 : fu_rr + FU_SIZE'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      rr_ptr      <= '0;
      fu_rr       <= '0;
      occ         <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
    end else if (flush_in) begin
      valid   <= '0;
      occ     <= '0;
      grant_q <= '0;
    end else begin
      valid   <= (valid & ~clr_mask) | set_mask;
      occ     <= occ_next;
      grant_q <= pick_found;
      rr_ptr  <= ptr_next;
      if (accept) fu_rr <= fu_rr_next;
      for (int f = 0; f < FU_ARRAY; f++) begin
        if (pick_found[f]) grant_idx_q[f] <= pick_idx[f];
      end
    end
  end

  assign dispatch_ready_out = ~full;
  assign alloc_idx_out      = free_idx;
  assign alloc_fu_out       = fu_rr;
  assign grant_valid_out    = grant_q;
  assign grant_idx_out      = grant_idx_q;
  assign occupancy_out      = occ;
  assign full_out           = full;
  assign empty_out          = (occ == '0);

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed plus randomized bench for rs_issue_scheduler against a
// slot-level behavioural model.
module tb_rs_issue_scheduler;

  localparam int N = 64;
  localparam int F = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_in;
  logic         dispatch_valid_in;
  logic         dispatch_ready_out;
  logic [5:0]   alloc_idx_out;
  logic [1:0]   alloc_fu_out;
  logic [63:0]  ready_vec_in;
  logic [127:0] entry_fu_in;
  logic [2:0]   fu_ready_in;
  logic [2:0]   grant_valid_out;
  logic [17:0]  grant_idx_out;
  logic [6:0]   occupancy_out;
  logic         full_out;
  logic         empty_out;

  rs_issue_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .flush_in           (flush_in),
    .dispatch_valid_in  (dispatch_valid_in),
    .dispatch_ready_out (dispatch_ready_out),
    .alloc_idx_out      (alloc_idx_out),
    .alloc_fu_out       (alloc_fu_out),
    .ready_vec_in       (ready_vec_in),
    .entry_fu_in        (entry_fu_in),
    .fu_ready_in        (fu_ready_in),
    .grant_valid_out    (grant_valid_out),
    .grant_idx_out      (grant_idx_out),
    .occupancy_out      (occupancy_out),
    .full_out           (full_out),
    .empty_out          (empty_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which slots hold an instruction, per-FU scan start,
  // next FU to assign, and the grants expected after the edge.
  bit mv[N];
  int mptr[F];
  int mfurr;
  int efu_tab[N];
  bit egv[F];
  int egi[F];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mocc();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mv[i]);
    return c;
  endfunction

  function automatic int mfree();
    for (int i = 0; i < N; i++) if (!mv[i]) return i;
    return -1;
  endfunction

  task automatic pack_fu();
    for (int i = 0; i < N; i++) entry_fu_in[i*2 +: 2] = efu_tab[i][1:0];
  endtask

  task automatic check_comb();
    int o;
    o = mocc();
    check("occupancy", occupancy_out, o);
    check("dispatch_ready", dispatch_ready_out, o < N);
    check("full", full_out, o == N);
    check("empty", empty_out, o == 0);
    check("alloc_fu", alloc_fu_out, mfurr);
    if (o < N) check("alloc_idx", alloc_idx_out, mfree());
  endtask

  task automatic cycle();
    int  fr;
    bit  acc;
    check_comb();
    if (rst) begin
      for (int i = 0; i < N; i++) mv[i] = 1'b0;
      for (int f = 0; f < F; f++) begin
        mptr[f] = 0; egv[f] = 1'b0; egi[f] = 0;
      end
      mfurr = 0;
    end else if (flush_in) begin
      for (int i = 0; i < N; i++) mv[i] = 1'b0;
      for (int f = 0; f < F; f++) egv[f] = 1'b0;
    end else begin
      fr  = mfree();
      acc = dispatch_valid_in && (mocc() < N);
      for (int f = 0; f < F; f++) begin
        egv[f] = 1'b0;
        if (fu_ready_in[f]) begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = (mptr[f] + k) % N;
            if (mv[j] && ready_vec_in[j] && efu_tab[j] == f) begin
              egv[f] = 1'b1; egi[f] = j; break;
            end
          end
        end
      end
      for (int f = 0; f < F; f++) begin
        if (egv[f]) begin
          mv[egi[f]] = 1'b0;
          mptr[f] = (egi[f] + 1) % N;
        end
      end
      if (acc) begin
        mv[fr] = 1'b1;
        mfurr = (mfurr + 1) % F;
      end
    end
    @(posedge clk);
    #1;
    for (int f = 0; f < F; f++) begin
      check($sformatf("grant_valid%0d", f), grant_valid_out[f], egv[f]);
      if (egv[f])
        check($sformatf("grant_idx%0d", f), grant_idx_out[f*6 +: 6], egi[f]);
    end
  endtask

  initial begin
    int exp3[3];
    logic [1:0] fu_before;
    exp3 = '{5, 9, 40};

    rst = 1'b1; flush_in = 1'b0; dispatch_valid_in = 1'b0;
    ready_vec_in = '0; fu_ready_in = '0;
    for (int i = 0; i < N; i++) efu_tab[i] = 0;
    pack_fu();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    for (int f = 0; f < F; f++) begin
      mptr[f] = 0; egv[f] = 1'b0; egi[f] = 0;
    end
    mfurr = 0;
    check_comb();
    check("rst_grant_valid", grant_valid_out, 0);
    check("rst_grant_idx", grant_idx_out, 0);
    rst = 1'b0;

    // four dispatches from empty
    dispatch_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tp1_alloc_idx", alloc_idx_out, i);
      check("tp1_alloc_fu", alloc_fu_out, i % 3);
      cycle();
    end
    check("tp1_occ", occupancy_out, 4);
    check("tp1_empty", empty_out, 0);

    // fill, then one extra dispatch attempt
    repeat (60) cycle();
    check("tp2_full", full_out, 1);
    check("tp2_ready", dispatch_ready_out, 0);
    cycle();
    dispatch_valid_in = 1'b0;
    check("tp2_occ", occupancy_out, 64);

    // three FU1 grants in rotating order
    efu_tab[5] = 1; efu_tab[9] = 1; efu_tab[40] = 1;
    pack_fu();
    ready_vec_in = '0;
    ready_vec_in[5] = 1'b1; ready_vec_in[9] = 1'b1; ready_vec_in[40] = 1'b1;
    fu_ready_in = 3'b010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("tp3_gv", grant_valid_out, 3'b010);
      check("tp3_gi", grant_idx_out[6 +: 6], exp3[i]);
    end
    check("tp3_ptr", dut.rr_ptr[1], 41);
    ready_vec_in = '0;
    dispatch_valid_in = 1'b1;
    repeat (3) cycle();
    dispatch_valid_in = 1'b0;
    check("tp3_refull", full_out, 1);

    // slot freed by a grant is reused at once
    efu_tab[7] = 1; pack_fu();
    ready_vec_in = '0; ready_vec_in[7] = 1'b1;
    cycle();
    check("tp4_gi", grant_idx_out[6 +: 6], 7);
    ready_vec_in = '0;
    dispatch_valid_in = 1'b1;
    check("tp4_alloc", alloc_idx_out, 7);
    cycle();
    dispatch_valid_in = 1'b0;
    check("tp4_occ", occupancy_out, 64);

    // dispatch and two grants in the same cycle at occupancy 10
    flush_in = 1'b1; cycle(); flush_in = 1'b0;
    check("tp5_flushed", occupancy_out, 0);
    dispatch_valid_in = 1'b1;
    repeat (10) cycle();
    efu_tab[2] = 0; efu_tab[4] = 2; pack_fu();
    ready_vec_in = '0; ready_vec_in[2] = 1'b1; ready_vec_in[4] = 1'b1;
    fu_ready_in = 3'b101;
    cycle();
    check("tp5_occ", occupancy_out, 9);
    check("tp5_gv", grant_valid_out, 3'b101);
    ready_vec_in = '0;
    repeat (11) cycle();
    check("tp6_occ20", occupancy_out, 20);

    // flush with dispatch pending, then reset
    flush_in = 1'b1;
    ready_vec_in = '1; fu_ready_in = 3'b111;
    fu_before = alloc_fu_out;
    cycle();
    flush_in = 1'b0; dispatch_valid_in = 1'b0;
    check("tp6_occ", occupancy_out, 0);
    check("tp6_gv", grant_valid_out, 0);
    check("tp6_fu_hold", alloc_fu_out, fu_before);
    ready_vec_in = '0;
    rst = 1'b1; cycle(); rst = 1'b0;
    check("tp7_ready", dispatch_ready_out, 1);
    check("tp7_alloc", alloc_idx_out, 0);
    check("tp7_fu", alloc_fu_out, 0);
    check("tp7_gv", grant_valid_out, 0);
    check("tp7_gi", grant_idx_out, 0);
    check("tp7_occ", occupancy_out, 0);
    check("tp7_full", full_out, 0);
    check("tp7_empty", empty_out, 1);

    // randomized traffic alternating fill and drain phases
    for (int c = 0; c < 3000; c++) begin
      bit fill;
      fill = ((c / 300) % 2) == 0;
      rst      = ($urandom_range(0, 299) == 0);
      flush_in = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) efu_tab[i] = $urandom_range(0, 3);
      pack_fu();
      if (fill) begin
        dispatch_valid_in = ($urandom_range(0, 9) < 9);
        ready_vec_in = {$urandom, $urandom} & {$urandom, $urandom}
                     & {$urandom, $urandom};
        fu_ready_in = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      end else begin
        dispatch_valid_in = ($urandom_range(0, 9) < 3);
        ready_vec_in = {$urandom, $urandom};
        fu_ready_in = 3'($urandom);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
